// File: rtl/mult_div_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_div_unit : iterative radix-2 MULTU/MULT/DIVU/DIV with HI/LO registers.
// Optional macro SIGNED_OPS_EN enables signed MULT/DIV (else all ops unsigned).
// Revision: 1.0
// ----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 dz_q, dz_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;

   // Operand magnitudes and signs at acceptance time
   logic                 sgn_op;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;

`ifdef SIGNED_OPS_EN
   assign sgn_op = op_i[0];
`else
   logic unused_op0;
   assign unused_op0 = op_i[0];
   assign sgn_op     = 1'b0;
`endif

   assign a_neg = sgn_op & a_i[WIDTH-1];
   assign b_neg = sgn_op & b_i[WIDTH-1];
   assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
   assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;

   // One shift-add multiply step: acc = {hi_partial, multiplier_remaining}
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring divide step: acc = {remainder, dividend_bits/quotient_bits}
   logic [WIDTH:0]       div_part;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_sub, div_rem;
   logic [2*WIDTH-1:0]   div_next;
   assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge   = (div_part >= {1'b0, m_q});
   assign div_sub  = div_part[WIDTH-1:0] - m_q;
   assign div_rem  = div_ge ? div_sub : div_part[WIDTH-1:0];
   assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

   logic [2*WIDTH-1:0]   step_next;
   assign step_next = is_div_q ? div_next : mul_next;

   // Sign fix-up applied once, on the final step's result
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix, fin_hi, fin_lo;
`ifdef SIGNED_OPS_EN
   assign prod_fix = neg_res_q ? (~mul_next + 1'b1) : mul_next;
   assign quo_fix  = neg_res_q ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1) : div_next[2*WIDTH-1:WIDTH];
`else
   assign prod_fix = mul_next;
   assign quo_fix  = div_next[WIDTH-1:0];
   assign rem_fix  = div_next[2*WIDTH-1:WIDTH];
`endif
   assign fin_hi = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign fin_lo = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      m_d       = m_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dz_d      = dz_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;

      case (state_q)
         S_RUN: begin
            acc_d = step_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
               hi_d    = fin_hi;
               lo_d    = fin_lo;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (start_i) begin
               dz_d = 1'b0;
               if (op_i[1] && (b_i == '0)) begin
                  // Divide by zero short-circuits straight to DONE
                  state_d = S_DONE;
                  hi_d    = a_i;
                  lo_d    = '1;
                  dz_d    = 1'b1;
               end else begin
                  state_d   = S_RUN;
                  cnt_d     = '0;
                  is_div_d  = op_i[1];
                  m_d       = op_i[1] ? b_mag : a_mag;
                  acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         m_q       <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dz_q      <= dz_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign busy_o     = (state_q == S_RUN);
   assign done_o     = (state_q == S_DONE);
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign div_zero_o = dz_q;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit for the MIPS datapath; the sequential companion to the combinational ALU. Executes MULTU/MULT/DIVU/DIV on WIDTH-bit operands, one radix-2 step per clock. Results land in architectural HI/LO registers, which are read by MFHI/MFLO. Start/busy/done handshake lets control stall the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (>= 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE or DONE
op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i
a_i  input  WIDTH  multiplicand / dividend (rs)
b_i  input  WIDTH  multiplier / divisor (rt)
busy_o  output  1  high while RUN; control stalls on it
done_o  output  1  one-cycle pulse, HI/LO just updated
hi_o  output  WIDTH  HI register (product upper half / remainder)
lo_o  output  WIDTH  LO register (product lower half / quotient)
div_zero_o  output  1  last division had divisor 0; held until next accepted start

Behaviour:
- Reset (async, reset==0): state IDLE, counter 0, busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0, internal regs 0. Reset mid-RUN aborts the operation; HI/LO go to 0.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 -> latch operands and op. Signed ops take magnitudes of a_i/b_i and record the result signs. Clear div_zero_o and go to RUN with counter=0. Exception: a divide with b_i==0 goes straight to DONE.
- RUN: busy_o=1. Each cycle does one step and increments the counter. Multiply step: shift-add on a 2*WIDTH accumulator. Divide step: restoring shift-subtract. After step WIDTH the state moves to DONE.
- Latency: start sampled at edge k; busy_o=1 for cycles k+1..k+WIDTH; done_o=1 and HI/LO updated in cycle k+WIDTH+1.
- DONE: done_o=1, busy_o=0, lasts exactly one cycle. HI/LO are written on the edge entering DONE. start_i=1 in DONE is accepted (back-to-back, same rules as IDLE); otherwise the state returns to IDLE.
- start_i during RUN is ignored and not queued. op_i, a_i and b_i may change freely after acceptance.
- HI/LO hold their value between operations; they change only on the edge entering DONE or on reset.
- Multiply result: {hi_o,lo_o} = full 2*WIDTH product. For MULT the product is negated if the operand signs differ.
- Divide result: lo_o = quotient, hi_o = remainder, truncation toward zero. For DIV the quotient is negative iff the signs differ; the remainder takes the dividend's sign.
- Signed overflow, DIV of -2^(WIDTH-1) by -1: lo_o=-2^(WIDTH-1) (wraps), hi_o=0, no flag.
- Divide by zero: lo_o=all ones, hi_o=a_i (raw operand), div_zero_o=1. Latency is 1 cycle: done_o in cycle k+1.
- Widths: all arithmetic is unsigned on magnitudes in internal WIDTH+1 / 2*WIDTH registers; sign fix-up is applied once at the end.

Optional Feature:
SIGNED_OPS_EN
- Defined: op_i[0] selects signed (MULT/DIV) with magnitude conversion and sign fix-up as above.
- Undefined: op_i[0] is ignored; every op is unsigned (MULT acts as MULTU, DIV as DIVU); sign logic is not synthesized.

Test Plan:
- MULTU, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done_o pulse; hi=0xFFFFFFFE, lo=0x00000001; busy_o high exactly 32 cycles.
- MULT (SIGNED_OPS_EN), a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, a=100, b=7 -> lo=14, hi=2.
- DIVU, a=0x1234, b=0 -> done_o in next cycle; lo=0xFFFFFFFF, hi=0x00001234, div_zero_o=1. A following MULTU start clears div_zero_o.
- start_i pulsed in RUN cycle 5 with different operands -> ignored; result matches the first op. start_i held in DONE -> second op accepted and done_o pulses again 33 cycles later.
- Assert reset at RUN cycle 10 -> busy_o, done_o, hi_o, lo_o all 0 immediately; after release, a new MULTU 6x7 gives lo=42, hi=0.
